serial_adder: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 21 ++
 rtl/serial_adder_if.sv | 25 ++
 rtl/serial_adder_add_slice.sv | 30 +++
 rtl/serial_adder.sv | 124 ++++++++++++
 tb/tb_serial_adder.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the slice-serial adder: FSM encoding and
// helpers that derive the cycle count from the operand/slice widths.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Number of RUN cycles needed to walk WIDTH bits in SLICE-bit steps.
    function automatic int calc_n(input int width, input int slice);
        return width / slice;
    endfunction

    // Legal geometry: slice fits in the word and divides it exactly.
    function automatic bit width_ok(input int width, input int slice);
        return (slice >= 1) && (slice <= width) && ((width % slice) == 0);
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result bundle for the serial adder. The requester drives the
// master side; the adder sits on the slave side.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             START;
    logic             SUB;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             BUSY;
    logic             VALID;
    logic [WIDTH-1:0] SUM;
    logic             CO;
    logic             OVF;

    modport master (
        output START, SUB, A, B,
        input  BUSY, VALID, SUM, CO, OVF
    );

    modport slave (
        input  START, SUB, A, B,
        output BUSY, VALID, SUM, CO, OVF
    );
endinterface

// File: rtl/serial_adder_add_slice.sv
// Combinational ripple of SLICE full adders. Also exposes the carry into
// the top bit so the caller can form two's-complement overflow.
module add_slice #(
    parameter int SLICE = 1
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             ci,
    output logic [SLICE-1:0] s,
    output logic             co,
    output logic             c_msb_in
);

    // Ripple the carry through each bit of the slice, LSB first.
    always_comb begin
        logic c;
        c        = ci;
        s        = '0;
        c_msb_in = ci;
        for (int i = 0; i < SLICE; i++) begin
            if (i == SLICE - 1) begin
                c_msb_in = c;
            end
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        co = c;
    end

endmodule

// File: rtl/serial_adder.sv
// Slice-serial add/subtract: WIDTH-bit operands processed SLICE bits per
// clock, LSB slice first, with a start/busy/valid handshake. Subtraction
// reuses the adder as A + ~B + 1.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SLICE = 1
) (
    input  logic          CLK,
    input  logic          RST,
    serial_adder_if.slave bus
);

    localparam int N  = calc_n(WIDTH, SLICE);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (!width_ok(WIDTH, SLICE)) begin : g_bad_geometry
            $error("serial_adder: WIDTH must be a multiple of SLICE and SLICE <= WIDTH");
        end
    endgenerate

    state_e           state_q;
    logic [WIDTH-1:0] ra_q;
    logic [WIDTH-1:0] rb_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             valid_q;
    logic             co_q;
    logic             ovf_q;

    logic [SLICE-1:0]       sl_s;
    logic                   sl_co;
    logic                   sl_cmsb;
    logic [WIDTH+SLICE-1:0] res_cat;
    logic [WIDTH-1:0]       res_d;
    logic [WIDTH-1:0]       ra_d;
    logic [WIDTH-1:0]       rb_d;
    logic [CW-1:0]          cnt_d;
    logic                   cnt_last;

    add_slice #(.SLICE(SLICE)) u_slice (
        .a        (ra_q[SLICE-1:0]),
        .b        (rb_q[SLICE-1:0]),
        .ci       (carry_q),
        .s        (sl_s),
        .co       (sl_co),
        .c_msb_in (sl_cmsb)
    );

    // New slice enters at the top of the result; the concatenation keeps
    // the shift legal even when SLICE equals WIDTH.
    assign res_cat  = {sl_s, res_q};
    assign res_d    = res_cat[WIDTH+SLICE-1:SLICE];
    assign ra_d     = ra_q >> SLICE;
    assign rb_d     = rb_q >> SLICE;
    assign cnt_d    = cnt_q + CW'(1);
    assign cnt_last = (cnt_q == CW'(N - 1));

    // Handshake FSM and datapath registers; all outputs are registered.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    valid_q <= 1'b0;
                    if (bus.START) begin
                        ra_q    <= bus.A;
                        rb_q    <= bus.SUB ? ~bus.B : bus.B;
                        carry_q <= bus.SUB;
                        cnt_q   <= '0;
                        res_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    ra_q    <= ra_d;
                    rb_q    <= rb_d;
                    res_q   <= res_d;
                    carry_q <= sl_co;
                    cnt_q   <= cnt_d;
                    if (cnt_last) begin
                        sum_q   <= res_d;
                        co_q    <= sl_co;
                        ovf_q   <= sl_co ^ sl_cmsb;
                        busy_q  <= 1'b0;
                        valid_q <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.BUSY  = busy_q;
    assign bus.VALID = valid_q;
    assign bus.SUM   = sum_q;
    assign bus.CO    = co_q;
    assign bus.OVF   = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench: two adders (SLICE=1 and SLICE=4, WIDTH=8). Stimulus
// pushes expected results; the negedge monitor pops and compares on VALID
// and also drains point checks queued by the stimulus process.
module tb_serial_adder;

    localparam int N1 = 8;
    localparam int N2 = 2;

    typedef struct packed {
        logic [7:0] sum;
        logic       co;
        logic       ovf;
    } exp_t;

    logic CLK = 1'b0;
    logic RST;

    always #5 CLK = ~CLK;

    serial_adder_if #(.WIDTH(8)) bus1 ();
    serial_adder_if #(.WIDTH(8)) bus2 ();

    serial_adder #(.WIDTH(8), .SLICE(1)) dut1 (.CLK(CLK), .RST(RST), .bus(bus1.slave));
    serial_adder #(.WIDTH(8), .SLICE(4)) dut2 (.CLK(CLK), .RST(RST), .bus(bus2.slave));

    exp_t        q1[$];
    exp_t        q2[$];
    string       cn_q[$];
    logic [31:0] ca_q[$];
    logic [31:0] ce_q[$];
    int          v2_cyc[$];

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int nv1    = 0;
    int nv2    = 0;
    int bc1    = 0;
    int bc2    = 0;

    // Monitor: drains point checks, counts BUSY cycles, scores each VALID.
    always @(negedge CLK) begin
        string       nm;
        logic [31:0] a;
        logic [31:0] e;
        exp_t        ex;
        exp_t        got;
        cyc++;
        while (cn_q.size() > 0) begin
            nm = cn_q.pop_front();
            a  = ca_q.pop_front();
            e  = ce_q.pop_front();
            n_chk++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL %s: actual %0h required %0h", nm, a, e);
            end
        end
        if (RST) begin
            bc1 = 0;
            bc2 = 0;
        end else begin
            if (bus1.BUSY) bc1++;
            if (bus2.BUSY) bc2++;
        end
        if (bus1.VALID) begin
            nv1++;
            got = {bus1.SUM, bus1.CO, bus1.OVF};
            n_chk++;
            if (q1.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_valid_dut1: sum=%h co=%b ovf=%b, none expected", bus1.SUM, bus1.CO, bus1.OVF);
            end else begin
                ex = q1.pop_front();
                if (got !== ex) begin
                    n_fail++;
                    $display("FAIL result_dut1: actual sum=%h co=%b ovf=%b required sum=%h co=%b ovf=%b",
                             got.sum, got.co, got.ovf, ex.sum, ex.co, ex.ovf);
                end
            end
            n_chk++;
            if (bc1 != N1 || bus1.BUSY !== 1'b0) begin
                n_fail++;
                $display("FAIL busy_dut1: actual cycles=%0d busy_now=%b required cycles=%0d busy_now=0", bc1, bus1.BUSY, N1);
            end
            bc1 = 0;
        end
        if (bus2.VALID) begin
            nv2++;
            v2_cyc.push_back(cyc);
            got = {bus2.SUM, bus2.CO, bus2.OVF};
            n_chk++;
            if (q2.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_valid_dut2: sum=%h co=%b ovf=%b, none expected", bus2.SUM, bus2.CO, bus2.OVF);
            end else begin
                ex = q2.pop_front();
                if (got !== ex) begin
                    n_fail++;
                    $display("FAIL result_dut2: actual sum=%h co=%b ovf=%b required sum=%h co=%b ovf=%b",
                             got.sum, got.co, got.ovf, ex.sum, ex.co, ex.ovf);
                end
            end
            n_chk++;
            if (bc2 != N2 || bus2.BUSY !== 1'b0) begin
                n_fail++;
                $display("FAIL busy_dut2: actual cycles=%0d busy_now=%b required cycles=%0d busy_now=0", bc2, bus2.BUSY, N2);
            end
            bc2 = 0;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        cn_q.push_back(nm);
        ca_q.push_back(act);
        ce_q.push_back(req);
    endtask

    task automatic wait_v1(input int target);
        for (int i = 0; i < 40 && nv1 < target; i++) begin
            @(negedge CLK);
            #1;
        end
        if (nv1 < target) push_chk("timeout_dut1", nv1, target);
    endtask

    task automatic wait_v2(input int target);
        for (int i = 0; i < 40 && nv2 < target; i++) begin
            @(negedge CLK);
            #1;
        end
        if (nv2 < target) push_chk("timeout_dut2", nv2, target);
    endtask

    // Single operation on the SLICE=1 adder with a hand-computed result.
    task automatic op1(input logic sub, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] s, input logic co, input logic ovf);
        int target;
        target = nv1 + 1;
        tick();
        bus1.SUB   = sub;
        bus1.A     = a;
        bus1.B     = b;
        bus1.START = 1'b1;
        q1.push_back('{sum: s, co: co, ovf: ovf});
        tick();
        bus1.START = 1'b0;
        wait_v1(target);
    endtask

    initial begin
        int saved;
        RST        = 1'b1;
        bus1.START = 1'b0;
        bus1.SUB   = 1'b0;
        bus1.A     = '0;
        bus1.B     = '0;
        bus2.START = 1'b0;
        bus2.SUB   = 1'b0;
        bus2.A     = '0;
        bus2.B     = '0;
        repeat (3) tick();
        @(negedge CLK);
        #1;
        push_chk("reset_dut1", {bus1.SUM, bus1.CO, bus1.OVF, bus1.BUSY, bus1.VALID}, 32'h0);
        push_chk("reset_dut2", {bus2.SUM, bus2.CO, bus2.OVF, bus2.BUSY, bus2.VALID}, 32'h0);
        tick();
        RST = 1'b0;

        op1(1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
        op1(1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
        op1(1'b1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0);
        op1(1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1);
        op1(1'b0, 8'h3C, 8'h4B, 8'h87, 1'b0, 1'b1);

        // Result must persist after VALID drops.
        repeat (3) tick();
        @(negedge CLK);
        #1;
        push_chk("hold_dut1", {bus1.SUM, bus1.CO, bus1.OVF}, {8'h87, 1'b0, 1'b1});

        // A second START during RUN with other operands is ignored.
        saved = nv1 + 1;
        tick();
        bus1.SUB   = 1'b0;
        bus1.A     = 8'h12;
        bus1.B     = 8'h34;
        bus1.START = 1'b1;
        q1.push_back('{sum: 8'h46, co: 1'b0, ovf: 1'b0});
        tick();
        bus1.START = 1'b0;
        tick();
        tick();
        bus1.SUB   = 1'b1;
        bus1.A     = 8'hFF;
        bus1.B     = 8'hFF;
        bus1.START = 1'b1;
        tick();
        bus1.START = 1'b0;
        wait_v1(saved);

        // Back-to-back on SLICE=4 with START held through RUN and DONE.
        saved = nv2 + 2;
        tick();
        bus2.SUB   = 1'b0;
        bus2.A     = 8'h12;
        bus2.B     = 8'h34;
        bus2.START = 1'b1;
        q2.push_back('{sum: 8'h46, co: 1'b0, ovf: 1'b0});
        q2.push_back('{sum: 8'h10, co: 1'b1, ovf: 1'b0});
        tick();
        bus2.A = 8'hF0;
        bus2.B = 8'h20;
        tick();
        tick();
        tick();
        bus2.START = 1'b0;
        wait_v2(saved);
        if (v2_cyc.size() >= 2)
            push_chk("valid_spacing_dut2", v2_cyc[v2_cyc.size()-1] - v2_cyc[v2_cyc.size()-2], 32'd3);
        else
            push_chk("valid_count_dut2", v2_cyc.size(), 32'd2);

        // Abort in the third RUN cycle of 0xAA+0x55.
        tick();
        bus1.SUB   = 1'b0;
        bus1.A     = 8'hAA;
        bus1.B     = 8'h55;
        bus1.START = 1'b1;
        tick();
        bus1.START = 1'b0;
        tick();
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        @(negedge CLK);
        #1;
        push_chk("abort_state_dut1", {bus1.SUM, bus1.CO, bus1.OVF, bus1.BUSY, bus1.VALID}, 32'h0);
        saved = nv1;
        repeat (12) tick();
        push_chk("abort_no_valid_dut1", nv1, saved);

        op1(1'b0, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0);

        repeat (3) tick();
        push_chk("pending_dut1", q1.size(), 32'd0);
        push_chk("pending_dut2", q2.size(), 32'd0);
        repeat (2) @(negedge CLK);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
